// File: rtl/pwm_melody_pkg.sv
// pwm_melody_pkg
//   Shared constants and types for the PWM melody tone engine:
//   note-table geometry, FSM state type and the fixed four-note table.
//   Half periods are in timing ticks; durations are in units of
//   2^DUR_SHIFT ticks. A half period of 0 marks a rest note.
package pwm_melody_pkg;

    localparam int unsigned NUM_NOTES  = 4;
    localparam int unsigned NOTE_IDX_W = 2;
    localparam int unsigned HALF_W     = 16;
    localparam int unsigned DUR_W      = 8;
    localparam int unsigned GAP_W      = 16;
    localparam int unsigned PRESC_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        TONE,
        GAP
    } state_e;

    localparam logic [HALF_W-1:0] NOTE_HALF [NUM_NOTES] = '{
        16'd1136, 16'd1012, 16'd0, 16'd851
    };

    localparam logic [DUR_W-1:0] NOTE_DUR [NUM_NOTES] = '{
        8'd4, 8'd4, 8'd2, 8'd8
    };

    // True when idx addresses the final entry of the note table.
    function automatic logic is_last_note(input logic [NOTE_IDX_W-1:0] idx);
        return idx == NOTE_IDX_W'(NUM_NOTES - 1);
    endfunction

endpackage

// File: rtl/pwm_melody_if.sv
// pwm_melody_if
//   Control/status bundle between the PWM register block and the tone
//   engine.
//   int_req  : start request, a rising edge starts the melody
//              (the register bit is named "int" in the register map)
//   stop     : level abort, forces the engine idle
//   pwm      : registered square-wave audio output
//   busy     : engine not idle
//   done     : one-cycle pulse on normal completion
//   note_idx : note currently playing or gapping
//   master = register block side, slave = tone engine side.
interface pwm_melody_if;
    import pwm_melody_pkg::*;

    logic                  int_req;
    logic                  stop;
    logic                  pwm;
    logic                  busy;
    logic                  done;
    logic [NOTE_IDX_W-1:0] note_idx;

    modport master (
        output int_req,
        output stop,
        input  pwm,
        input  busy,
        input  done,
        input  note_idx
    );

    modport slave (
        input  int_req,
        input  stop,
        output pwm,
        output busy,
        output done,
        output note_idx
    );

endinterface

// File: rtl/pwm_note_rom.sv
// pwm_note_rom
//   Combinational note table lookup.
//   note_idx    : table index
//   half_period : half period of the note in ticks (0 = rest)
//   duration    : note length in units of 2^DUR_SHIFT ticks
module pwm_note_rom
    import pwm_melody_pkg::*;
(
    input  logic [NOTE_IDX_W-1:0] note_idx,
    output logic [HALF_W-1:0]     half_period,
    output logic [DUR_W-1:0]      duration
);

    always_comb begin
        half_period = NOTE_HALF[note_idx];
        duration    = NOTE_DUR[note_idx];
    end

endmodule

// File: rtl/pwm_melody_core.sv
// pwm_melody_core
//   Tone engine: on a rising edge of the start request, plays the fixed
//   four-note table as square waves, each note followed by a silent gap,
//   then returns idle and pulses done. stop aborts at any time.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : control/status bundle (slave side), see pwm_melody_if
//   Parameters: TICK_DIV cycles per tick, note unit 2^DUR_SHIFT ticks,
//   GAP_TICKS silent ticks after each note.
module pwm_melody_core
    import pwm_melody_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50,
    parameter int unsigned DUR_SHIFT = 14,
    parameter int unsigned GAP_TICKS = 1000
) (
    input  logic         clk,
    input  logic         reset,
    pwm_melody_if.slave  bus
);

    localparam int unsigned DUR_CNT_W = DUR_W + DUR_SHIFT;

    state_e                 state_q, state_d;
    logic                   int_q, int_d;
    logic                   armed_q, armed_d;
    logic [PRESC_W-1:0]     presc_q, presc_d;
    logic [HALF_W-1:0]      half_q, half_d;
    logic [DUR_CNT_W-1:0]   dur_q, dur_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [NOTE_IDX_W-1:0]  note_q, note_d;
    logic                   pwm_q, pwm_d;
    logic                   done_q, done_d;

    logic                   tick;
    logic                   start;
    logic                   load_note;
    logic [NOTE_IDX_W-1:0]  rom_idx;
    logic [HALF_W-1:0]      rom_half;
    logic [DUR_W-1:0]       rom_dur;

    // In GAP the table is addressed one ahead so the next note can be
    // loaded on the gap's final tick; IDLE always holds note_q at 0.
    assign rom_idx = (state_q == GAP) ? note_q + NOTE_IDX_W'(1) : note_q;

    pwm_note_rom u_rom (
        .note_idx    (rom_idx),
        .half_period (rom_half),
        .duration    (rom_dur)
    );

    assign tick = (presc_q == PRESC_W'(TICK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        int_d     = bus.int_req;
        armed_d   = 1'b1;
        presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
        half_d    = half_q;
        dur_d     = dur_q;
        gap_d     = gap_q;
        note_d    = note_q;
        pwm_d     = pwm_q;
        done_d    = 1'b0;
        load_note = 1'b0;

        // armed_q blocks the first cycle after reset: int_q has not yet
        // seen the real input level, so a level held through reset would
        // otherwise look like a rising edge.
        start = bus.int_req & ~int_q & armed_q;

        if (bus.stop) begin
            state_d = IDLE;
            pwm_d   = 1'b0;
            note_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = TONE;
                        note_d    = '0;
                        load_note = 1'b1;
                    end
                end

                TONE: begin
                    if (tick) begin
                        if (dur_q == DUR_CNT_W'(1)) begin
                            // End of note wins over a coincident toggle.
                            state_d = GAP;
                            pwm_d   = 1'b0;
                            gap_d   = GAP_W'(GAP_TICKS);
                        end else begin
                            dur_d = dur_q - DUR_CNT_W'(1);
                            if (half_q != '0) begin
                                if (half_q == HALF_W'(1)) begin
                                    pwm_d  = ~pwm_q;
                                    half_d = rom_half;
                                end else begin
                                    half_d = half_q - HALF_W'(1);
                                end
                            end
                        end
                    end
                end

                GAP: begin
                    if (tick) begin
                        if (gap_q == GAP_W'(1)) begin
                            if (is_last_note(note_q)) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                                note_d  = '0;
                            end else begin
                                state_d   = TONE;
                                note_d    = note_q + NOTE_IDX_W'(1);
                                load_note = 1'b1;
                            end
                        end else begin
                            gap_d = gap_q - GAP_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    pwm_d   = 1'b0;
                    note_d  = '0;
                end
            endcase
        end

        if (load_note) begin
            half_d = rom_half;
            dur_d  = DUR_CNT_W'(rom_dur) << DUR_SHIFT;
            pwm_d  = (rom_half != '0);
        end

        // Restart the prescaler on every state entry so each state's
        // first tick lands TICK_DIV cycles after entry.
        if ((state_d != state_q) || (state_q == IDLE)) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
            armed_q <= 1'b0;
            presc_q <= '0;
            half_q  <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            note_q  <= '0;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            armed_q <= armed_d;
            presc_q <= presc_d;
            half_q  <= half_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            note_q  <= note_d;
            pwm_q   <= pwm_d;
            done_q  <= done_d;
        end
    end

    assign bus.pwm      = pwm_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.note_idx = note_q;

endmodule

// File: tb/tb_pwm_melody_core.sv
// tb_pwm_melody_core
//   Two engines on one clock: A (TICK_DIV=1, DUR_SHIFT=12, GAP=16) and
//   B (TICK_DIV=4, DUR_SHIFT=10, GAP=16). A timeline model derives the
//   expected outputs from the elapsed cycles since playback began.
module tb_pwm_melody_core;

    localparam int unsigned P_TD [2] = '{1, 4};
    localparam int unsigned P_SH [2] = '{12, 10};
    localparam int unsigned P_GP [2] = '{16, 16};
    localparam int unsigned HALF_T [4] = '{1136, 1012, 0, 851};
    localparam int unsigned DUR_T  [4] = '{4, 4, 2, 8};

    logic clk = 1'b0;
    logic rst_r  [2] = '{1'b0, 1'b0};
    logic int_r  [2] = '{1'b0, 1'b0};
    logic stop_r [2] = '{1'b0, 1'b0};

    int total = 0;
    int bad   = 0;
    bit fin   = 1'b0;

    always #5 clk = ~clk;

    pwm_melody_if ifa ();
    pwm_melody_if ifb ();

    assign ifa.int_req = int_r[0];
    assign ifa.stop    = stop_r[0];
    assign ifb.int_req = int_r[1];
    assign ifb.stop    = stop_r[1];

    pwm_melody_core #(.TICK_DIV(1), .DUR_SHIFT(12), .GAP_TICKS(16)) dut_a (
        .clk   (clk),
        .reset (rst_r[0]),
        .bus   (ifa.slave)
    );

    pwm_melody_core #(.TICK_DIV(4), .DUR_SHIFT(10), .GAP_TICKS(16)) dut_b (
        .clk   (clk),
        .reset (rst_r[1]),
        .bus   (ifb.slave)
    );

    // ---------------- timeline model ----------------
    function automatic longint note_len(int d, int i);
        return longint'(DUR_T[i]) * (longint'(1) << P_SH[d]) * longint'(P_TD[d]);
    endfunction

    function automatic longint gap_len(int d);
        return longint'(P_GP[d]) * longint'(P_TD[d]);
    endfunction

    function automatic longint seq_len(int d);
        longint s = 0;
        for (int i = 0; i < 4; i++) s += note_len(d, i) + gap_len(d);
        return s;
    endfunction

    // Output while playing, e cycles after the entry edge of note 0.
    function automatic void play_at(input int d, input longint e,
                                    output logic p, output logic [1:0] idx);
        longint r = e;
        p   = 1'b0;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r < note_len(d, i)) begin
                idx = 2'(i);
                if (HALF_T[i] != 0)
                    p = ((r / (longint'(HALF_T[i]) * longint'(P_TD[d]))) % 2) == 0;
                return;
            end
            r -= note_len(d, i);
            if (r < gap_len(d)) begin
                idx = 2'(i);
                return;
            end
            r -= gap_len(d);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_model
        bit         playing  = 1'b0;
        longint     cyc      = 0;
        longint     start_c  = 0;
        longint     done_c   = -1;
        logic       int_prev = 1'b1;
        logic       exp_pwm  = 1'b0;
        logic       exp_busy = 1'b0;
        logic       exp_done = 1'b0;
        logic [1:0] exp_idx  = 2'd0;

        always @(posedge clk or posedge rst_r[g]) begin
            if (rst_r[g]) begin
                // Level on int during reset is unknown history: no edge.
                playing  = 1'b0;
                int_prev = 1'b1;
                done_c   = -1;
                exp_pwm  = 1'b0;
                exp_busy = 1'b0;
                exp_done = 1'b0;
                exp_idx  = 2'd0;
            end else begin
                cyc++;
                if (stop_r[g]) begin
                    playing = 1'b0;
                end else if (!playing) begin
                    if (int_r[g] && !int_prev) begin
                        playing = 1'b1;
                        start_c = cyc;
                    end
                end else if (cyc - start_c == seq_len(g)) begin
                    playing = 1'b0;
                    done_c  = cyc;
                end
                int_prev = int_r[g];
                if (playing) begin
                    play_at(g, cyc - start_c, exp_pwm, exp_idx);
                    exp_busy = 1'b1;
                    exp_done = 1'b0;
                end else begin
                    exp_pwm  = 1'b0;
                    exp_busy = 1'b0;
                    exp_idx  = 2'd0;
                    exp_done = (done_c == cyc);
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string nm, input logic ap, input logic ab,
                           input logic ad, input logic [1:0] ai,
                           input logic ep, input logic eb,
                           input logic ed, input logic [1:0] ei);
        total++;
        if ({ap, ab, ad, ai} !== {ep, eb, ed, ei}) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s t=%0t: got pwm=%b busy=%b done=%b idx=%0d expected pwm=%b busy=%b done=%b idx=%0d",
                         nm, $time, ap, ab, ad, ai, ep, eb, ed, ei);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- engine A ----------------
    task automatic run_a();
        int     toggles;
        logic   prev;
        longint k;
        longint got;

        // Reset with int held high: no playback afterwards.
        step(3);
        rst_r[0] = 1'b0;
        step(50);
        chk("a_held_int_busy", ifa.busy, 0);
        chk("a_held_int_pwm", ifa.pwm, 0);

        int_r[0] = 1'b0;
        step(2);
        int_r[0] = 1'b1;
        step(1);
        chk("a_start_busy", ifa.busy, 1);
        chk("a_start_pwm", ifa.pwm, 1);
        chk("a_start_idx", ifa.note_idx, 0);

        stop_r[0] = 1'b1;
        step(1);
        chk("a_stop_busy", ifa.busy, 0);
        int_r[0] = 1'b0;
        step(2);
        stop_r[0] = 1'b0;
        step(2);

        // int and stop rising together: no start, then no late start.
        int_r[0]  = 1'b1;
        stop_r[0] = 1'b1;
        step(3);
        chk("a_int_stop_busy", ifa.busy, 0);
        stop_r[0] = 1'b0;
        step(3);
        chk("a_after_stop_busy", ifa.busy, 0);
        int_r[0] = 1'b0;
        step(2);

        // Full melody.
        int_r[0] = 1'b1;
        step(1);
        prev    = ifa.pwm;
        toggles = 0;
        for (int i = 1; i <= 16383; i++) begin
            step(1);
            if (ifa.pwm != prev) toggles++;
            prev = ifa.pwm;
        end
        chk("a_note0_toggles", toggles, 14);
        k   = 16383;
        got = -1;
        while (k < 80000) begin
            step(1);
            k++;
            if (ifa.done) begin
                got = k;
                break;
            end
        end
        chk("a_done_cycle", got, 73792);
        step(1);
        chk("a_done_width", ifa.done, 0);
        chk("a_end_busy", ifa.busy, 0);
        chk("a_end_idx", ifa.note_idx, 0);
        int_r[0] = 1'b0;
        step(2);
    endtask

    // ---------------- engine B ----------------
    task automatic run_b();
        logic   prev;
        longint t1;
        longint t2;

        step(2);
        rst_r[1] = 1'b0;
        step(2);
        int_r[1] = 1'b1;
        step(1);
        prev = ifb.pwm;
        t1   = -1;
        t2   = -1;
        for (longint k = 1; k <= 10000; k++) begin
            step(1);
            if (ifb.pwm != prev) begin
                if (t1 < 0) t1 = k;
                else if (t2 < 0) t2 = k;
            end
            prev = ifb.pwm;
        end
        chk("b_first_toggle", t1, 4544);
        chk("b_half_period", t2 - t1, 4544);

        // Abort two thousand cycles into note 1.
        step(8448);
        chk("b_in_note1_idx", ifb.note_idx, 1);
        chk("b_in_note1_busy", ifb.busy, 1);
        stop_r[1] = 1'b1;
        int_r[1]  = 1'b0;
        step(1);
        chk("b_abort_busy", ifb.busy, 0);
        chk("b_abort_pwm", ifb.pwm, 0);
        chk("b_abort_done", ifb.done, 0);
        stop_r[1] = 1'b0;
        step(2);
        int_r[1] = 1'b1;
        step(1);
        chk("b_restart_busy", ifb.busy, 1);
        chk("b_restart_idx", ifb.note_idx, 0);
        chk("b_restart_pwm", ifb.pwm, 1);

        // Into the gap after note 0, then reset between edges.
        step(16404);
        chk("b_gap_pwm", ifb.pwm, 0);
        chk("b_gap_busy", ifb.busy, 1);
        #2;
        rst_r[1] = 1'b1;
        #1;
        chk("b_async_pwm", ifb.pwm, 0);
        chk("b_async_busy", ifb.busy, 0);
        chk("b_async_done", ifb.done, 0);
        chk("b_async_idx", ifb.note_idx, 0);
        step(3);
        rst_r[1] = 1'b0;
        step(200);
        chk("b_no_resume_busy", ifb.busy, 0);
        chk("b_no_resume_pwm", ifb.pwm, 0);
    endtask

    initial begin
        #1;
        rst_r[0] = 1'b1;
        rst_r[1] = 1'b1;
        int_r[0] = 1'b1;
        fork
            begin
                fork
                    run_a();
                    run_b();
                join
                fin = 1'b1;
            end
            begin
                while (!fin) begin
                    @(negedge clk);
                    cmp_dut("a_cycle", ifa.pwm, ifa.busy, ifa.done, ifa.note_idx,
                            g_model[0].exp_pwm, g_model[0].exp_busy,
                            g_model[0].exp_done, g_model[0].exp_idx);
                    cmp_dut("b_cycle", ifb.pwm, ifb.busy, ifb.done, ifb.note_idx,
                            g_model[1].exp_pwm, g_model[1].exp_busy,
                            g_model[1].exp_done, g_model[1].exp_idx);
                end
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
